// File: rtl/rv32_alu_pkg.sv
// Shared types for the two-pass ALU issue controller: ALU select codes,
// sequencer states and the default WAIT timeout.
package rv32_alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        AND = 2'b01,
        OR  = 2'b10,
        XOR = 2'b11
    } alu_sel_t;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WAIT,
        RESP
    } alu_ctrl_state_t;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rv32_rr_arbiter.sv
// Combinational round-robin picker: the first requester found scanning
// upward (with wrap) from the one after last_grant_i wins.
module rv32_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    always_comb begin
        int pos;
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        pos         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = (int'(last_grant_i) + i) % NUM_REQ;
            if (!any_o && req_i[IDX_W'(pos)]) begin
                grant_o[IDX_W'(pos)] = 1'b1;
                grant_idx_o          = IDX_W'(pos);
                any_o                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32_alu_issue_ctrl.sv
// Round-robin issue controller for the two-pass 16-bit-slice ALU: grants one
// requester, steps the ALU through LO/HI, waits for valid and returns the result.
module rv32_alu_issue_ctrl
    import rv32_alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [NUM_REQ*32-1:0] i_req_op_a,
    input  logic [NUM_REQ*32-1:0] i_req_op_b,
    input  logic [NUM_REQ*2-1:0]  i_req_sel,
    output logic [NUM_REQ-1:0]    o_rsp_valid,
    input  logic [NUM_REQ-1:0]    i_rsp_ready,
    output logic [31:0]           o_rsp_result,
    output logic                  o_rsp_carry,
    output logic                  o_rsp_err,
    output logic                  o_alu_clr,
    output logic                  o_alu_en,
    output logic [31:0]           o_alu_op_a,
    output logic [31:0]           o_alu_op_b,
    output logic [1:0]            o_alu_sel,
    output logic                  o_alu_hold,
    input  logic                  i_alu_valid,
    input  logic [31:0]           i_alu_result,
    input  logic                  i_alu_carry,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_op_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    alu_ctrl_state_t  state_q, state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    alu_sel_t         sel_q, sel_d;
    logic [31:0]      result_q, result_d;
    logic             carry_q, carry_d, err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    rv32_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (i_req_valid),
        .last_grant_i(last_grant_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        sel_d        = sel_q;
        result_d     = result_q;
        carry_d      = carry_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        op_count_d   = op_count_q;
        o_req_ready  = '0;
        o_rsp_valid  = '0;
        o_alu_clr    = 1'b0;
        o_alu_en     = 1'b0;
        o_alu_hold   = 1'b0;
        case (state_q)
            IDLE: begin
                // No grant during the reset cycle so a dropped request is never half-accepted.
                if (grant_any && !i_rst) begin
                    o_req_ready = grant;
                    o_alu_clr   = 1'b1;
                    id_d        = grant_idx;
                    op_a_d      = i_req_op_a[32*grant_idx +: 32];
                    op_b_d      = i_req_op_b[32*grant_idx +: 32];
                    sel_d       = alu_sel_t'(i_req_sel[2*grant_idx +: 2]);
                    state_d     = LO;
                end
            end
            LO: begin
                o_alu_en = 1'b1;
                state_d  = HI;
            end
            HI: begin
                o_alu_en = 1'b1;
                tmo_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                o_alu_hold = 1'b1;
                if (i_alu_valid) begin
                    result_d = i_alu_result;
                    carry_d  = (sel_q == ADD) && i_alu_carry;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    carry_d  = 1'b0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RESP: begin
                o_alu_hold       = 1'b1;
                o_rsp_valid[id_q] = 1'b1;
                if (i_rsp_ready[id_q]) begin
                    last_grant_d = id_q;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            sel_q        <= ADD;
            result_q     <= '0;
            carry_q      <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            sel_q        <= sel_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            op_count_q   <= op_count_d;
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_alu_op_a   = o_busy ? op_a_q : '0;
    assign o_alu_op_b   = o_busy ? op_b_q : '0;
    assign o_alu_sel    = o_busy ? sel_q : 2'b00;
    assign o_rsp_result = (state_q == RESP) ? result_q : '0;
    assign o_rsp_carry  = (state_q == RESP) && carry_q;
    assign o_rsp_err    = (state_q == RESP) && err_q;
    assign o_op_count   = op_count_q;

endmodule

// File: doc/rv32_alu_issue_ctrl.md
Name: rv32_alu_issue_ctrl

Overview:
Sequencer and arbiter in front of the two-pass 16-bit-slice ALU in the decode/execute stage. It accepts ALU requests from NUM_REQ requesters (execute path, LSU address generation) and grants them round-robin. It drives the ALU through a clear / low-half / high-half / wait-valid sequence and returns the 32-bit result, carry and a timeout error to the winning requester with a valid/ready handshake.

Parameters:
NUM_REQ, 2, number of requesters (at least 2).
TIMEOUT, 16, maximum WAIT cycles allowed before the op completes with an error.
CNT_W, 16, width of the completed-operation counter.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_req_valid  in  NUM_REQ  per-requester request valid
o_req_ready  out  NUM_REQ  one-hot accept; only the winner, only in IDLE
i_req_op_a  in  NUM_REQ*32  operand A, requester k at bits [32k+31:32k]
i_req_op_b  in  NUM_REQ*32  operand B, same packing
i_req_sel  in  NUM_REQ*2  ALU select, requester k at bits [2k+1:2k]
o_rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester
i_rsp_ready  in  NUM_REQ  per-requester response accept
o_rsp_result  out  32  result (shared bus)
o_rsp_carry  out  1  carry out of bit 31 (ADD only, else 0)
o_rsp_err  out  1  1 means timeout; result and carry are forced to 0
o_alu_clr  out  1  one-cycle clear of the ALU phase counter
o_alu_en  out  1  ALU step enable
o_alu_op_a  out  32  latched operand A
o_alu_op_b  out  32  latched operand B
o_alu_sel  out  2  latched select
o_alu_hold  out  1  freezes the ALU result while waiting or responding
i_alu_valid  in  1  ALU result valid
i_alu_result  in  32  ALU result
i_alu_carry  in  1  ALU carry
o_busy  out  1  1 whenever the state is not IDLE
o_op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset: i_rst is synchronous and active-high; clock is i_clk.
  - State returns to IDLE. last_grant is set to NUM_REQ-1, so requester 0 wins first.
  - Every output is 0 and o_op_count is 0.
  - Reset mid-operation silently drops the in-flight request; no response is issued.
- States: IDLE, LO, HI, WAIT, RESP.
- IDLE:
  - If any i_req_valid is set, winner w is the first valid index scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - o_req_ready[w]=1 combinationally in that cycle and o_alu_clr=1.
  - At the clock edge: latch op_a, op_b, sel and id=w, then go to LO. With no valid request, stay in IDLE.
- LO: o_alu_en=1, operands driven from the latches; next state is HI.
- HI: o_alu_en=1; clear the timeout counter; next state is WAIT.
- WAIT:
  - o_alu_en=0, o_alu_hold=1.
  - If i_alu_valid: capture i_alu_result, and capture i_alu_carry when sel=ADD (else 0); err=0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without valid: err=1, result=0, carry=0, go to RESP.
  - i_alu_valid is sampled only in WAIT.
- RESP:
  - o_rsp_valid[id]=1 and o_alu_hold=1.
  - o_rsp_result, o_rsp_carry and o_rsp_err stay stable until the handshake.
  - On i_rsp_ready[id]: last_grant<=id, o_op_count increments, go to IDLE.
  - i_rsp_ready of non-owning requesters is ignored.
- Latency and throughput:
  - Minimum latency is 4 cycles from the IDLE accept cycle to the first RESP cycle, when valid arrives in the first WAIT cycle.
  - Minimum occupancy is 5 cycles per op; there is no overlap between ops.
- Arbitration and handshake:
  - No new grant is made while busy. Requests stay pending and must remain stable until o_req_ready.
  - Simultaneous requests resolve round-robin.
  - o_req_ready depends only on i_req_valid, state and last_grant, never on operands.
- The ALU-side outputs keep the latched values from LO through RESP and drop to 0 in IDLE.

Decomposition:
- Package rv32_alu_pkg holds:
  - alu_sel_t enum: ADD=2'b00, AND=2'b01, OR=2'b10, XOR=2'b11.
  - alu_ctrl_state_t enum: IDLE, LO, HI, WAIT, RESP.
  - TIMEOUT default constant.
- Sub-module rv32_rr_arbiter (parameter NUM_REQ):
  - Inputs: request vector, last_grant index.
  - Outputs: one-hot grant, grant index, any-grant flag.
  - Purely combinational.

Test Plan:
1. Single ADD on requester 0: a=0x0001FFFF, b=0x00000001, ALU model asserts valid in the first WAIT cycle with result 0x00020000 and carry 0.
   -> o_rsp_valid=2'b01 four cycles after accept; result 0x00020000, carry 0, err 0; o_op_count=1.
2. Both requesters valid at cycle 0 after reset, both ops XOR 0xFFFF0000 ^ 0x0F0F0F0F.
   -> req0 is granted first, then req1; each gets result 0xF0F00F0F.
   -> After a second simultaneous request pair, req0 is granted again.
3. ALU model never asserts valid.
   -> After TIMEOUT cycles in WAIT: o_rsp_err=1, result 0x00000000, carry 0; the FSM returns to IDLE after the handshake.
4. In RESP, hold i_rsp_ready[0] low for 5 cycles while req1 is valid.
   -> rsp_valid, result and o_alu_hold stay stable; o_req_ready stays 0; req1 is granted only after the handshake.
5. Assert i_rst for 1 cycle while in WAIT.
   -> The next cycle shows state IDLE, all outputs 0 and o_op_count 0; with both requests valid, req0 is granted next.
6. ADD with a=0xFFFFFFFF, b=0x00000001 and ALU carry 1.
   -> result 0x00000000, o_rsp_carry=1.
   -> An AND op with i_alu_carry=1 reports carry 0.
